// File: rtl/kbms_pkg.sv
// Shared types for the keyboard/mouse event arbiter: event width, source ids,
// capture FSM states and the output event record.
package kbms_pkg;
  localparam int EV_W = 16;

  typedef enum logic {SRC_KB = 1'b0, SRC_MS = 1'b1} src_e;

  typedef enum logic {CAP_IDLE = 1'b0, CAP_DRAIN = 1'b1} cap_state_e;

  typedef struct packed {
    logic            is_mouse;
    logic [EV_W-1:0] data;
  } event_t;
endpackage

// File: rtl/kbms_event_arbiter_fifo.sv
// ev_fifo: synchronous event FIFO, zero-latency read head, pointers carry a wrap bit.
// A push into a full FIFO is accepted only with a same-cycle pop; ovwr replaces the newest entry.
module ev_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     ovwr,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] tail_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_ovwr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign dout     = mem[rd_ptr[AW-1:0]];
  assign tail_idx = wr_ptr[AW-1:0] - AW'(1);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Overwrite only applies when the normal push path cannot take the word.
  assign do_ovwr = ovwr && full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)      mem[wr_ptr[AW-1:0]] <= din;
    else if (do_ovwr) mem[tail_idx]       <= din;
  end
endmodule

// File: rtl/kbms_event_arbiter.sv
// Drains the link receiver into kb/ms FIFOs and round-robins them onto one registered event stream;
// capture-to-ev_valid is one edge, output holds under !ev_ready. MOUSE_COALESCE_EN: full mouse FIFO overwrites newest.
module kbms_event_arbiter
  import kbms_pkg::*;
#(
  parameter int KB_DEPTH = 4,
  parameter int MS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_data_ready,
  input  logic                        rx_is_mouse,
  input  logic [15:0]                 rx_data,
  output logic                        rx_retrieved,
  output logic                        ev_valid,
  output logic                        ev_is_mouse,
  output logic [15:0]                 ev_data,
  input  logic                        ev_ready,
  output logic [$clog2(KB_DEPTH):0]   kb_level,
  output logic [$clog2(MS_DEPTH):0]   ms_level,
  output logic                        ovf_kb,
  output logic                        ovf_ms,
  input  logic                        ovf_clr
);
  cap_state_e cap_state, cap_next;
  logic       cap;
  src_e       last_grant;
  event_t     ev_q;

  logic            kb_push, ms_push, kb_pop, ms_pop, ms_ovwr;
  logic            kb_full, kb_empty, ms_full, ms_empty;
  logic            kb_drop, ms_drop, load_en, take_kb, take_ms;
  logic [EV_W-1:0] kb_dout, ms_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap_state <= CAP_IDLE;
    else        cap_state <= cap_next;
  end

  // DRAIN gives the receiver one cycle to clear data_ready after the acknowledge.
  always_comb begin
    cap_next = cap_state;
    cap      = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (rx_data_ready) begin
          cap      = 1'b1;
          cap_next = CAP_DRAIN;
        end
      end
      CAP_DRAIN: cap_next = CAP_IDLE;
      default:   cap_next = CAP_IDLE;
    endcase
  end

  assign rx_retrieved = (cap_state == CAP_DRAIN);
  assign kb_push      = cap && !rx_is_mouse;
  assign ms_push      = cap &&  rx_is_mouse;

  assign load_en = !ev_valid || ev_ready;
  assign take_kb = !kb_empty && (ms_empty || last_grant == SRC_MS);
  assign take_ms = !ms_empty && !take_kb;
  assign kb_pop  = load_en && take_kb;
  assign ms_pop  = load_en && take_ms;

  assign kb_drop = kb_push && kb_full && !kb_pop;
`ifdef MOUSE_COALESCE_EN
  assign ms_ovwr = ms_push && ms_full && !ms_pop;
  assign ms_drop = 1'b0;
`else
  assign ms_ovwr = 1'b0;
  assign ms_drop = ms_push && ms_full && !ms_pop;
`endif

  ev_fifo #(.DEPTH(KB_DEPTH), .W(EV_W)) u_kb_fifo (
    .clk(clk), .rst_n(rst_n), .push(kb_push), .ovwr(1'b0), .din(rx_data),
    .pop(kb_pop), .dout(kb_dout), .full(kb_full), .empty(kb_empty), .level(kb_level)
  );

  ev_fifo #(.DEPTH(MS_DEPTH), .W(EV_W)) u_ms_fifo (
    .clk(clk), .rst_n(rst_n), .push(ms_push), .ovwr(ms_ovwr), .din(rx_data),
    .pop(ms_pop), .dout(ms_dout), .full(ms_full), .empty(ms_empty), .level(ms_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid   <= 1'b0;
      ev_q       <= '0;
      last_grant <= SRC_MS;
    end else if (load_en) begin
      ev_valid <= kb_pop || ms_pop;
      if (kb_pop) begin
        ev_q       <= '{is_mouse: 1'b0, data: kb_dout};
        last_grant <= SRC_KB;
      end else if (ms_pop) begin
        ev_q       <= '{is_mouse: 1'b1, data: ms_dout};
        last_grant <= SRC_MS;
      end
    end
  end

  assign ev_is_mouse = ev_q.is_mouse;
  assign ev_data     = ev_q.data;

  // A set in the same cycle as ovf_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_kb <= 1'b0;
      ovf_ms <= 1'b0;
    end else begin
      if (kb_drop)      ovf_kb <= 1'b1;
      else if (ovf_clr) ovf_kb <= 1'b0;
      if (ms_drop)      ovf_ms <= 1'b1;
      else if (ovf_clr) ovf_ms <= 1'b0;
    end
  end
endmodule

// File: tb/tb_kbms_event_arbiter.sv
// Directed bench for kbms_event_arbiter: scoreboard of expected events, immediate-assertion checks.
module tb_kbms_event_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_data_ready = 1'b0;
  logic        rx_is_mouse = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_retrieved;
  logic        ev_valid;
  logic        ev_is_mouse;
  logic [15:0] ev_data;
  logic        ev_ready = 1'b1;
  logic [2:0]  kb_level;
  logic [2:0]  ms_level;
  logic        ovf_kb;
  logic        ovf_ms;
  logic        ovf_clr = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          ret_cnt = 0;
  logic        ret_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [16:0] held = '0;
  logic [16:0] exp_q[$];

  kbms_event_arbiter #(.KB_DEPTH(4), .MS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_ready(rx_data_ready), .rx_is_mouse(rx_is_mouse), .rx_data(rx_data),
    .rx_retrieved(rx_retrieved),
    .ev_valid(ev_valid), .ev_is_mouse(ev_is_mouse), .ev_data(ev_data), .ev_ready(ev_ready),
    .kb_level(kb_level), .ms_level(ms_level),
    .ovf_kb(ovf_kb), .ovf_ms(ovf_ms), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor and acknowledge-rate monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
      ret_prev   = 1'b0;
    end else begin
      if (ev_valid && stall_prev) check("hold_stable", 32'({ev_is_mouse, ev_data}), 32'(held));
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_event: observed 0x%0h expected none", {ev_is_mouse, ev_data});
        end else begin
          e = exp_q.pop_front();
          check("event", 32'({ev_is_mouse, ev_data}), 32'(e));
        end
      end
      stall_prev = ev_valid && !ev_ready;
      held       = {ev_is_mouse, ev_data};
      if (rx_retrieved) begin
        ret_cnt++;
        if (ret_prev) begin
          checks++;
          errors++;
          $error("FAIL retrieved_b2b: observed two adjacent pulses expected gap of 1 cycle");
        end
      end
      ret_prev = rx_retrieved;
    end
  end

  // Called just after a rising edge; returns just after the edge that captured the word.
  task automatic send(input logic m, input logic [15:0] d, input bit expect_out, input bit hold);
    int n;
    rx_data_ready = 1'b1;
    rx_is_mouse   = m;
    rx_data       = d;
    if (expect_out) exp_q.push_back({m, d});
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rx_retrieved && n < 20);
    check("retrieved_seen", 32'(rx_retrieved), 32'h1);
    if (!hold) rx_data_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'h0);
    check("drain_valid", 32'(ev_valid), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_retrieved"}, 32'(rx_retrieved), 32'h0);
    check({tag, "_ev_valid"},  32'(ev_valid), 32'h0);
    check({tag, "_ev_mouse"},  32'(ev_is_mouse), 32'h0);
    check({tag, "_ev_data"},   32'(ev_data), 32'h0);
    check({tag, "_kb_level"},  32'(kb_level), 32'h0);
    check({tag, "_ms_level"},  32'(ms_level), 32'h0);
    check({tag, "_ovf_kb"},    32'(ovf_kb), 32'h0);
    check({tag, "_ovf_ms"},    32'(ovf_ms), 32'h0);
  endtask

  initial begin
    int r0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single keyboard word, one-edge latency to ev_valid.
    send(1'b0, 16'h1A2B, 1'b1, 1'b0);
    check("t1_level_after_cap", 32'(kb_level), 32'h1);
    check("t1_valid_at_cap", 32'(ev_valid), 32'h0);
    @(posedge clk); #1;
    check("t1_retrieved_one_cycle", 32'(rx_retrieved), 32'h0);
    check("t1_valid", 32'(ev_valid), 32'h1);
    check("t1_data", 32'(ev_data), 32'h1A2B);
    check("t1_is_mouse", 32'(ev_is_mouse), 32'h0);
    check("t1_kb_level", 32'(kb_level), 32'h0);
    wait_drain();

    // Round-robin alternation under stall.
    ev_ready = 1'b0;
    send(1'b0, 16'h0001, 1'b1, 1'b0);
    send(1'b1, 16'h8002, 1'b1, 1'b0);
    send(1'b0, 16'h0003, 1'b1, 1'b0);
    send(1'b1, 16'h8004, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_held_data", 32'(ev_data), 32'h0001);
    check("t2_kb_level", 32'(kb_level), 32'h1);
    check("t2_ms_level", 32'(ms_level), 32'h2);
    ev_ready = 1'b1;
    wait_drain();

    // Keyboard overflow.
    ev_ready = 1'b0;
    r0 = ret_cnt;
    for (int i = 0; i < 6; i++) send(1'b0, 16'h0010 + 16'(i), (i < 5), 1'b0);
    @(posedge clk); #1;
    check("t3_ovf_kb", 32'(ovf_kb), 32'h1);
    check("t3_ovf_ms", 32'(ovf_ms), 32'h0);
    check("t3_kb_level", 32'(kb_level), 32'h4);
    check("t3_ret_count", 32'(ret_cnt - r0), 32'h6);
    ev_ready = 1'b1;
    wait_drain();
    check("t3_ovf_sticky", 32'(ovf_kb), 32'h1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", 32'(ovf_kb), 32'h0);

    // Mouse overflow: coalesce build keeps the latest word instead of flagging.
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef MOUSE_COALESCE_EN
      send(1'b1, 16'h0020 + 16'(i), (i != 4), 1'b0);
`else
      send(1'b1, 16'h0020 + 16'(i), (i < 5), 1'b0);
`endif
    end
    @(posedge clk); #1;
`ifdef MOUSE_COALESCE_EN
    check("t4_ovf_ms", 32'(ovf_ms), 32'h0);
`else
    check("t4_ovf_ms", 32'(ovf_ms), 32'h1);
`endif
    check("t4_ms_level", 32'(ms_level), 32'h4);
    check("t4_ovf_kb", 32'(ovf_kb), 32'h0);
    ev_ready = 1'b1;
    wait_drain();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("t4_ovf_cleared", 32'(ovf_ms), 32'h0);

    // Asynchronous reset mid-stall.
    ev_ready = 1'b0;
    send(1'b0, 16'h0050, 1'b0, 1'b0);
    send(1'b1, 16'h8051, 1'b0, 1'b0);
    send(1'b0, 16'h0052, 1'b0, 1'b0);
    check("t5_pre_valid", 32'(ev_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ev_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 16'h0042, 1'b1, 1'b0);
    wait_drain();
    check("t5_kb_level", 32'(kb_level), 32'h0);
    check("t5_ms_level", 32'(ms_level), 32'h0);

    // Receiver keeps data_ready high; the bench swaps in a new word after each acknowledge.
    r0 = ret_cnt;
    for (int i = 0; i < 4; i++) send(i[0], 16'h0060 + 16'(i), 1'b1, (i < 3));
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      n += 32'(rx_retrieved);
    end
    check("t6_no_extra_ack", 32'(n), 32'h0);
    check("t6_ret_count", 32'(ret_cnt - r0), 32'h4);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kbms_event_arbiter.md
Name: kbms_event_arbiter

Overview:
Sits between the keyboard link receiver and the monitor-port/host interface. Drains the receiver's single-entry data register (data_ready / retrieved handshake) into separate keyboard and mouse FIFOs, so the serial link never stalls. A round-robin arbiter merges both FIFOs onto one registered valid/ready event stream. Sticky overflow flags report dropped events.

Parameters:
KB_DEPTH, 4, keyboard FIFO entries (power of 2, >=2)
MS_DEPTH, 4, mouse FIFO entries (power of 2, >=2)

Ports:
clk  in  1  monitor clock
rst_n  in  1  asynchronous active-low reset
rx_data_ready  in  1  receiver holds an unread 16-bit word
rx_is_mouse  in  1  1 = mouse word, 0 = keyboard word
rx_data  in  16  received word
rx_retrieved  out  1  one-cycle pulse; receiver clears data_ready
ev_valid  out  1  output event valid
ev_is_mouse  out  1  source of ev_data
ev_data  out  16  event word
ev_ready  in  1  downstream accepts when ev_valid && ev_ready
kb_level  out  $clog2(KB_DEPTH)+1  keyboard FIFO occupancy
ms_level  out  $clog2(MS_DEPTH)+1  mouse FIFO occupancy
ovf_kb  out  1  sticky: keyboard word dropped
ovf_ms  out  1  sticky: mouse word dropped
ovf_clr  in  1  clears both sticky flags

Behaviour:
- Reset (async assert, sync release) clears all outputs, FIFOs and arbiter state. rx_retrieved=0, ev_valid=0, ev_is_mouse=0, ev_data=0, levels=0, ovf_*=0, capture FSM in IDLE, last_grant=MOUSE (keyboard wins first tie).
- Capture FSM:
  - IDLE: if rx_data_ready is high, push {rx_is_mouse, rx_data} into the selected FIFO, pulse rx_retrieved for one cycle, and go to DRAIN.
  - DRAIN: wait one cycle, which covers the receiver's register clear. Then go to IDLE. rx_data_ready is ignored in DRAIN.
  - Result: at most one capture every 2 cycles, far faster than the 54 us link bit time.
- Full target FIFO at capture: the word is dropped, the matching ovf flag is set, and rx_retrieved still pulses, so the link is always acknowledged.
- FIFO push and pop of the same FIFO in the same cycle are legal when the FIFO is full: level is unchanged and the push is not dropped (the pop frees the slot).
- ovf_clr has lower priority than a set in the same cycle: the flag stays 1.
- Output stage: a single register.
  - Loads when ev_valid=0, or when ev_valid && ev_ready.
  - Source selection: if only one FIFO is non-empty, take it. If both are non-empty, take the one opposite last_grant. last_grant updates on every load.
  - Holds ev_data/ev_is_mouse stable while ev_valid && !ev_ready.
  - Back-to-back streaming: one event per cycle while ev_ready=1.
- Latency: a word captured at edge N into empty FIFOs, with the output register empty, gives ev_valid=1 after edge N+1.
- Level outputs count FIFO contents only, excluding the word held in the output register.
- Pointer arithmetic is modulo depth, with an extra wrap bit for full/empty detection.

Optional Feature:
MOUSE_COALESCE_EN
- Defined: a mouse capture while the mouse FIFO is full overwrites the newest mouse entry (latest motion wins). ovf_ms is never set. If a pop of that FIFO happens in the same cycle, the push proceeds normally instead.
- Undefined: the mouse word is dropped and ovf_ms is set, same as keyboard.
- Keyboard behaviour is identical in both builds.

Decomposition:
- Package kbms_pkg: EV_W=16, source enum {SRC_KB=0, SRC_MS=1}, capture FSM state enum {CAP_IDLE, CAP_DRAIN}, event struct {is_mouse, data}.
- Sub-module ev_fifo (parameter DEPTH, width 16):
  - Synchronous push/pop, full/empty/level outputs, async active-low reset.
  - Optional overwrite-tail input used for coalescing.
  - Instantiated twice.

Test Plan:
- After reset, one keyboard word 0x1A2B (rx_is_mouse=0) with ev_ready=1 -> rx_retrieved pulses exactly 1 cycle; ev_valid=1 one edge after capture, ev_data=0x1A2B, ev_is_mouse=0; kb_level returns to 0.
- With ev_ready=0, capture kb 0x0001 then ms 0x8002, kb 0x0003, ms 0x8004, then raise ev_ready -> output order is 0x0001, then 0x8002, 0x0003, 0x8004 (round-robin alternation), with data held stable while stalled.
- With ev_ready=0 and KB_DEPTH=4, capture 6 keyboard words 0x10..0x15 -> the first word goes to the output register, the next 4 fill the FIFO, and 0x15 is dropped. ovf_kb=1, rx_retrieved pulsed 6 times, and the drain yields 0x10..0x14. ovf_clr then gives ovf_kb=0.
- Same overflow with mouse words 0x20..0x25 and MOUSE_COALESCE_EN defined -> ovf_ms stays 0 and the drain yields 0x20,0x21,0x22,0x23,0x25.
- Assert rst_n low mid-stall, with the FIFOs partially full and ev_valid=1 -> all outputs reach reset values immediately. After release, a new capture of 0x0042 is delivered alone.
- rx_data_ready held high continuously -> rx_retrieved pulses no more often than every 2 cycles, and there is no duplicate push of the same word.
